fetch_sequencer: RTL and testbench

Program-counter and fetch-control stage sitting directly upstream of the instruction memory. Drives PCAddress/EnIM into the 1-cycle registered-read instruction memory and captures the returned Instruction word with its PC. Presents fetched words to decode over a valid/ready handshake, buffered in a 2-entry skid buffer. Accepts branch/jump redirects that flush in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 72 +++++++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, defaults and the skid-buffer entry type for the fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned PC_STEP_DEF = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Instruction fetches are word aligned; the low two address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order FIFO between the instruction memory response and decode.
// Entry 0 is always the head, so head data comes straight from a register.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic [1:0]  count,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc
);

    fetch_entry_t entry0_r;
    fetch_entry_t entry1_r;
    fetch_entry_t in_s;
    logic [1:0]   count_r;
    logic         do_pop_s;
    logic         do_push_s;

    assign in_s      = '{instr: push_instr, pc: push_pc};
    assign do_pop_s  = pop && (count_r != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push_s = push && ((count_r != 2'(DEPTH)) || do_pop_s);

    // Entry storage and occupancy; flush discards everything ahead of any push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= in_s;
                    end else begin
                        entry1_r <= in_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    entry1_r <= '0;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_r <= in_s;
                    end else begin
                        entry0_r <= entry1_r;
                        entry1_r <= in_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign count      = count_r;
    assign head_instr = entry0_r.instr;
    assign head_pc    = entry0_r.pc;

endmodule

// File: rtl/fetch_sequencer.sv
// PC generation, credit-based issue and redirect handling in front of a 1-cycle instruction memory.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall / perf_flush counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_STEP   = PC_STEP_DEF,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_address,
    output logic        en_im,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    logic [31:0] pc_r;
    logic [31:0] inflight_pc_r;
    logic        inflight_r;
    logic [1:0]  count_s;
    logic [2:0]  occupancy_s;
    logic        pop_s;
    logic        push_s;
    logic        issue_s;

    assign pop_s       = out_valid && out_ready;
    assign push_s      = inflight_r && !redirect_valid;
    // Words held or on their way after this cycle's pop; a new read needs a free slot for its reply.
    assign occupancy_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s     = !rst && !redirect_valid && (occupancy_s <= 3'(BUF_DEPTH - 1));

    assign en_im      = issue_s;
    assign pc_address = pc_r;
    assign out_valid  = (count_s != 2'd0);

    // PC and in-flight tracking; a redirect cancels the outstanding read and retargets the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'd0;
        end else if (redirect_valid) begin
            pc_r       <= align_word(redirect_pc);
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
                pc_r          <= pc_r + 32'(PC_STEP);
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    fetch_skid_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_instr (instruction),
        .push_pc    (inflight_pc_r),
        .pop        (pop_s),
        .count      (count_s),
        .head_instr (out_instr),
        .head_pc    (out_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;

    // Free-running wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_r <= 32'd0;
            perf_stall_r   <= 32'd0;
            perf_flush_r   <= 32'd0;
        end else begin
            if (push_s) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (redirect_valid && (inflight_r || (count_s != 2'd0))) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
    assign perf_flush   = perf_flush_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, wrap-around, redirect, mid-stream reset and stall/drain.
// Define FETCH_PERF_CNT_EN to also check the performance counters.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic        out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] instruction2;
    logic [31:0] pc_address, out_instr, out_pc;
    logic [31:0] pc_address2, out_instr2, out_pc2;
    logic        en_im, out_valid, en_im2, out_valid2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
    logic [31:0] perf_fetched2, perf_stall2, perf_flush2;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .pc_address     (pc_address),
        .en_im          (en_im),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    fetch_sequencer #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .pc_address     (pc_address2),
        .en_im          (en_im2),
        .instruction    (instruction2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .out_valid      (out_valid2),
        .out_ready      (1'b1),
        .out_instr      (out_instr2),
        .out_pc         (out_pc2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched2),
        .perf_stall     (perf_stall2),
        .perf_flush     (perf_flush2)
`endif
    );

    // Instruction memory contents: bytes 0..11 big-endian, elsewhere an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0120_0007;
            32'h0000_0004: return 32'h1345_0000;
            32'h0000_0008: return 32'h3630_0436;
            default:       return 32'hA000_0000 ^ a;
        endcase
    endfunction

    // Registered-read memory models, one per DUT.
    always @(posedge clk) begin
        if (en_im) instruction <= mem_word(pc_address);
        if (en_im2) instruction2 <= mem_word(pc_address2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string ph, input int c, input logic e_en, input logic [31:0] e_addr,
                             input logic e_ov, input logic [31:0] e_opc);
        chk($sformatf("%s%0d_en_im", ph, c), {31'd0, en_im}, {31'd0, e_en});
        chk($sformatf("%s%0d_pc_address", ph, c), pc_address, e_addr);
        chk($sformatf("%s%0d_out_valid", ph, c), {31'd0, out_valid}, {31'd0, e_ov});
        if (e_ov) begin
            chk($sformatf("%s%0d_out_pc", ph, c), out_pc, e_opc);
            chk($sformatf("%s%0d_out_instr", ph, c), out_instr, mem_word(e_opc));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streaming with out_ready=1 after reset; second DUT starts at FFFF_FFF8.
    logic        b_en   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] b_addr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic        b_ov   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] b_opc  [5] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
    logic [31:0] w_addr [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    logic [31:0] w_opc  [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};

    // Back-to-back redirects (0x40 then 0x13) while pc 0 is at the head and pc 4 is in flight.
    logic        c_rv   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] c_rpc  [8] = '{32'h0, 32'h0, 32'h40, 32'h13, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        c_en   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] c_addr [8] = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h10, 32'h14, 32'h18, 32'h1C};
    logic        c_ov   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] c_opc  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h10, 32'h14};

    // Stall from cycle 0 until cycle 6, then drain.
    logic        d_en   [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] d_addr [10] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10, 32'h14};
    logic        d_ov   [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] d_opc  [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        tick();
        tick();
        chk("rst_en_im", {31'd0, en_im}, 32'd0);
        chk("rst_pc_address", pc_address, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_wrap_pc_address", pc_address2, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
`endif

        for (int c = 0; c < 5; c++) begin
            tick();
            rst       = 1'b0;
            out_ready = 1'b1;
            #1;
            chk_cycle("stream", c, b_en[c], b_addr[c], b_ov[c], b_opc[c]);
            chk($sformatf("wrap%0d_pc_address", c), pc_address2, w_addr[c]);
            chk($sformatf("wrap%0d_out_valid", c), {31'd0, out_valid2}, {31'd0, b_ov[c]});
            if (b_ov[c]) chk($sformatf("wrap%0d_out_pc", c), out_pc2, w_opc[c]);
        end
        chk("wrap_out_instr", out_instr2, mem_word(32'h0));
`ifdef FETCH_PERF_CNT_EN
        chk("wrap_perf_fetched", perf_fetched2, 32'd3);
        chk("wrap_perf_stall", perf_stall2, 32'd0);
        chk("wrap_perf_flush", perf_flush2, 32'd0);
`endif

        tick();
        rst = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            rst            = 1'b0;
            out_ready      = 1'b1;
            redirect_valid = c_rv[c];
            redirect_pc    = c_rpc[c];
            #1;
            chk_cycle("redir", c, c_en[c], c_addr[c], c_ov[c], c_opc[c]);
        end

        // Reset while streaming with a word buffered and a read outstanding.
        tick();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("mrst_en_im", {31'd0, en_im}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("redir_perf_fetched", perf_fetched, 32'd4);
        chk("redir_perf_stall", perf_stall, 32'd0);
        chk("redir_perf_flush", perf_flush, 32'd1);
`endif
        tick();
        out_ready = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_out_instr", out_instr, 32'h0);
        chk("mrst_out_pc", out_pc, 32'h0);
        chk("mrst_en_im_next", {31'd0, en_im}, 32'd0);
        chk("mrst_pc_address", pc_address, 32'h0);

        for (int c = 0; c < 10; c++) begin
            tick();
            rst       = 1'b0;
            out_ready = (c >= 6);
            #1;
            chk_cycle("stall", c, d_en[c], d_addr[c], d_ov[c], d_opc[c]);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stall_perf_fetched", perf_fetched, 32'd4);
        chk("stall_perf_stall", perf_stall, 32'd4);
        chk("stall_perf_flush", perf_flush, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
